// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the single data memory (one sync read port, one write port) between
//   the core MEM stage and an external host port (loader / debug / DMA).
//   The core always wins a port it is using and sees no added latency; the
//   host gets a port only when the core leaves it idle. Arbitration is per
//   port, so a host write can run alongside a core load and vice versa.
//
//   Optional starvation guard: define DATA_ARB_STARVE_EN. After STARVE_LIMIT
//   consecutive blocked host cycles, one FORCE cycle stalls the core and hands
//   the host its port.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_core_rd_*/o_core_rd_data core load request, data one cycle later
//   i_core_wr*                core store (size 00 none/01 byte/10 half/11 word)
//   o_core_stall              core must re-present its MEM request next cycle
//   i_host_req_*/o_host_req_ready   host valid/ready request channel
//   o_host_rsp_valid/rdata    host response, exactly one cycle after accept
//   o_mem_* / i_mem_rd_data   data memory ports
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_core_rd_en,
    input  logic [ADDR_W-1:0] i_core_rd_addr,
    output logic [DATA_W-1:0] o_core_rd_data,
    input  logic [1:0]        i_core_wr,
    input  logic [ADDR_W-1:0] i_core_wr_addr,
    input  logic [DATA_W-1:0] i_core_wr_data,
    output logic              o_core_stall,
    input  logic              i_host_req_valid,
    output logic              o_host_req_ready,
    input  logic              i_host_req_we,
    input  logic [1:0]        i_host_req_size,
    input  logic [ADDR_W-1:0] i_host_req_addr,
    input  logic [DATA_W-1:0] i_host_req_wdata,
    output logic              o_host_rsp_valid,
    output logic [DATA_W-1:0] o_host_rsp_rdata,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic [1:0]        o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data
);

    logic w_port_busy;
    logic w_force;
    logic w_grant;
    logic w_host_rd;
    logic w_host_wr;
    logic r_rsp_pending;
    logic r_rsp_is_read;

    // Host contends only for the one port its request needs.
    assign w_port_busy = i_host_req_we ? (i_core_wr != 2'b00) : i_core_rd_en;
    assign w_grant     = i_rst_n && i_host_req_valid && (!w_port_busy || w_force);
    assign w_host_rd   = w_grant && !i_host_req_we;
    assign w_host_wr   = w_grant &&  i_host_req_we;

    assign o_host_req_ready = w_grant;

`ifdef DATA_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_RUN, ST_FORCE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;

    always_comb begin
        w_wait_nxt  = r_wait_cnt;
        w_state_nxt = r_state;
        if (!i_host_req_valid || w_grant)
            w_wait_nxt = '0;
        else if (r_wait_cnt != CNT_W'(STARVE_LIMIT))
            w_wait_nxt = r_wait_cnt + 1'b1;
        // Entering FORCE as the count reaches the limit means FORCE coincides
        // with wait_cnt == STARVE_LIMIT; the granted host then clears it.
        case (r_state)
            ST_RUN:   if (w_wait_nxt == CNT_W'(STARVE_LIMIT)) w_state_nxt = ST_FORCE;
            ST_FORCE: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign w_force      = (r_state == ST_FORCE);
    assign o_core_stall = i_rst_n && w_force;
`else
    assign w_force      = 1'b0;
    assign o_core_stall = 1'b0;
`endif

    // Read port: host address only when the host owns it, core otherwise.
    assign o_mem_rd_addr  = w_host_rd ? i_host_req_addr : i_core_rd_addr;
    // The core never loads while the host owns the read port, so no gating.
    assign o_core_rd_data = i_mem_rd_data;

    // Write port. A stalled core re-presents its store next cycle, so any
    // core store is dropped during FORCE to avoid landing it twice.
    always_comb begin
        o_mem_wr      = 2'b00;
        o_mem_wr_addr = i_core_wr_addr;
        o_mem_wr_data = i_core_wr_data;
        if (w_host_wr) begin
            o_mem_wr      = i_host_req_size;
            o_mem_wr_addr = i_host_req_addr;
            o_mem_wr_data = i_host_req_wdata;
        end else if (i_rst_n && !w_force) begin
            o_mem_wr      = i_core_wr;
        end
    end

    // Single response stage: memory read data arrives the cycle after accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_pending <= 1'b0;
            r_rsp_is_read <= 1'b0;
        end else begin
            r_rsp_pending <= w_grant;
            r_rsp_is_read <= w_host_rd;
        end
    end

    // Gate with reset so a response pending at reset assertion never shows.
    assign o_host_rsp_valid = i_rst_n && r_rsp_pending;
    assign o_host_rsp_rdata = (i_rst_n && r_rsp_pending && r_rsp_is_read) ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_rd_en;
    logic [AW-1:0] core_rd_addr;
    logic [DW-1:0] core_rd_data;
    logic [1:0]    core_wr;
    logic [AW-1:0] core_wr_addr;
    logic [DW-1:0] core_wr_data;
    logic          core_stall;
    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_req_we;
    logic [1:0]    host_req_size;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata;
    logic          host_rsp_valid;
    logic [DW-1:0] host_rsp_rdata;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [1:0]    mem_wr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_rd_en(core_rd_en), .i_core_rd_addr(core_rd_addr), .o_core_rd_data(core_rd_data),
        .i_core_wr(core_wr), .i_core_wr_addr(core_wr_addr), .i_core_wr_data(core_wr_data),
        .o_core_stall(core_stall),
        .i_host_req_valid(host_req_valid), .o_host_req_ready(host_req_ready),
        .i_host_req_we(host_req_we), .i_host_req_size(host_req_size),
        .i_host_req_addr(host_req_addr), .i_host_req_wdata(host_req_wdata),
        .o_host_rsp_valid(host_rsp_valid), .o_host_rsp_rdata(host_rsp_rdata),
        .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_data(mem_rd_data),
        .o_mem_wr(mem_wr), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'hDEADBEEF;      // byte address 0x40
        return 32'h1000_0000 ^ (i * 32'h9E37_79B9);
    endfunction

    // Byte-addressed store into a little-endian 32-bit word.
    function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] size,
                                          logic [AW-1:0] addr, logic [31:0] data);
        logic [31:0] r;
        int lane;
        r = old;
        lane = int'(addr[1:0]);
        case (size)
            2'b01: r[8*lane +: 8] = data[7:0];
            2'b10: r[16*(lane/2) +: 16] = data[15:0];
            2'b11: r = data;
            default: r = old;
        endcase
        return r;
    endfunction

    // Data memory seen by the DUT: 64 words, sync read returning old data.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_rd_addr[7:2]];
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_wr != 2'b00) begin
            mem[mem_wr_addr[7:2]] <= merge(mem[mem_wr_addr[7:2]], mem_wr, mem_wr_addr, mem_wr_data);
        end
    end

    // ---------------- reference model + scoreboard producer ----------------
    typedef struct { int due; logic [31:0] data; } rsp_t;
    rsp_t q[$];

    logic [DW-1:0] ref_mem [64];
    int            waits;
    logic          core_chk;
    logic [DW-1:0] core_exp;

    initial begin : model
        logic blocked, force_now, e_ready, e_stall, e_hrd;
        logic [1:0] e_wr;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        waits = 0;
        core_chk = 1'b0;
        core_exp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
                waits = 0;
                core_chk = 1'b0;
                tests++;
                if (host_req_ready !== 1'b0 || mem_wr !== 2'b00 || core_stall !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_outputs: ready=%b mem_wr=%b stall=%b, need 0/00/0",
                             host_req_ready, mem_wr, core_stall);
                end
            end else begin
                if (core_chk) begin
                    tests++;
                    if (core_rd_data !== core_exp) begin
                        fails++;
                        $display("FAIL core_rd_data cyc=%0d: got %h need %h", cyc, core_rd_data, core_exp);
                    end
                end
                blocked = host_req_we ? (core_wr != 2'b00) : core_rd_en;
`ifdef DATA_ARB_STARVE_EN
                force_now = (waits == LIM);
`else
                force_now = 1'b0;
`endif
                e_ready = host_req_valid && (!blocked || force_now);
                e_stall = force_now;
                e_hrd   = e_ready && !host_req_we;
                tests++;
                if (host_req_ready !== e_ready || core_stall !== e_stall) begin
                    fails++;
                    $display("FAIL grant cyc=%0d: ready=%b stall=%b need ready=%b stall=%b",
                             cyc, host_req_ready, core_stall, e_ready, e_stall);
                end
                if (e_ready)
                    q.push_back('{cyc + 1, host_req_we ? 32'h0 : ref_mem[host_req_addr[7:2]]});
                if (e_hrd) begin
                    tests++;
                    if (mem_rd_addr !== host_req_addr) begin
                        fails++;
                        $display("FAIL rd_addr cyc=%0d: got %h need %h", cyc, mem_rd_addr, host_req_addr);
                    end
                end
                core_chk = core_rd_en && !e_hrd && !e_stall;
                core_exp = ref_mem[core_rd_addr[7:2]];
                // Who owns the write port this cycle.
                e_wr = 2'b00; e_wa = '0; e_wd = '0;
                if (e_ready && host_req_we) begin
                    e_wr = host_req_size; e_wa = host_req_addr; e_wd = host_req_wdata;
                end else if (core_wr != 2'b00 && !e_stall) begin
                    e_wr = core_wr; e_wa = core_wr_addr; e_wd = core_wr_data;
                end
                tests++;
                if (mem_wr !== e_wr || (e_wr != 2'b00 && (mem_wr_addr !== e_wa || mem_wr_data !== e_wd))) begin
                    fails++;
                    $display("FAIL mem_write cyc=%0d: got %b@%h=%h need %b@%h=%h",
                             cyc, mem_wr, mem_wr_addr, mem_wr_data, e_wr, e_wa, e_wd);
                end
                if (e_wr != 2'b00)
                    ref_mem[e_wa[7:2]] = merge(ref_mem[e_wa[7:2]], e_wr, e_wa, e_wd);
                if (host_req_valid && !e_ready) waits = (waits < LIM) ? waits + 1 : LIM;
                else waits = 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tests++;
                if (host_rsp_valid !== 1'b0 || host_rsp_rdata !== '0) begin
                    fails++;
                    $display("FAIL rsp_in_reset: valid=%b rdata=%h need 0/0", host_rsp_valid, host_rsp_rdata);
                end
                q.delete();
            end else if (host_rsp_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected cyc=%0d: rdata=%h, none expected", cyc, host_rsp_rdata);
                end else begin
                    e = q.pop_front();
                    if (e.due != cyc || host_rsp_rdata !== e.data) begin
                        fails++;
                        $display("FAIL rsp_data cyc=%0d: got %h need %h due cyc %0d",
                                 cyc, host_rsp_rdata, e.data, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL rsp_missing cyc=%0d: valid=0 need response %h", cyc, q[0].data);
                e = q.pop_front();
            end
        end
    end

    // ---------------- stimulus ----------------
    logic acc, stl;

    task automatic step();
        @(negedge clk);
        #1;
        acc = host_req_ready;
        stl = core_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        core_rd_en = 0; core_wr = 2'b00;
    endtask

    task automatic host_set(logic v, logic we, logic [1:0] sz, logic [AW-1:0] a, logic [DW-1:0] d);
        host_req_valid = v; host_req_we = we; host_req_size = sz;
        host_req_addr = a; host_req_wdata = d;
    endtask

    initial begin
        logic hold_h;
        int n;
        rst_n = 0; acc = 0; stl = 0;
        core_idle(); core_rd_addr = '0; core_wr_addr = '0; core_wr_data = '0;
        host_set(0, 0, 2'b00, '0, '0);
        repeat (3) step();
        rst_n = 1;

        // Host read of preloaded word, core idle.
        host_set(1, 0, 2'b00, 32'h40, '0);
        step();
        host_set(0, 0, 2'b00, '0, '0);
        step();

        // Host write alongside a core load, then read it back.
        core_rd_en = 1; core_rd_addr = 32'h10;
        host_set(1, 1, 2'b11, 32'h20, 32'hA5A5A5A5);
        step();
        core_idle(); host_set(1, 0, 2'b00, 32'h20, '0);
        step();
        host_set(0, 0, 2'b00, '0, '0);
        step();

        // Core stores every cycle while host write waits.
        host_set(1, 1, 2'b11, 32'h24, 32'h1234_5678);
        for (int k = 0; k < 5; k++) begin
            if (!stl) begin
                core_wr = 2'b11; core_wr_addr = 32'h80 + 32'(4 * k); core_wr_data = $urandom;
            end
            step();
            if (acc) host_req_valid = 0;
        end
        core_idle();
        n = 0;
        while (host_req_valid && n < 4) begin
            step();
            if (acc) host_req_valid = 0;
            n++;
        end
        step();

        // Four back-to-back host reads.
        for (int k = 0; k < 4; k++) begin
            host_set(1, 0, 2'b00, 32'(4 * k), '0);
            step();
        end
        host_set(0, 0, 2'b00, '0, '0);
        step();

        // Reset right after an accepted read: response must be dropped.
        host_set(1, 0, 2'b00, 32'h40, '0);
        step();
        host_set(0, 0, 2'b00, '0, '0);
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        repeat (3) step();

        // Randomized traffic.
        hold_h = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold_h)
                host_set(($urandom % 3) != 0, $urandom % 2, 2'($urandom_range(1, 3)),
                         32'($urandom_range(0, 255)), $urandom);
            if (!stl) begin
                core_rd_en   = $urandom % 2;
                core_rd_addr = 32'($urandom_range(0, 255));
                core_wr      = ($urandom % 2) ? 2'($urandom_range(1, 3)) : 2'b00;
                core_wr_addr = 32'($urandom_range(0, 255));
                core_wr_data = $urandom;
            end
            step();
            hold_h = host_req_valid && !acc;
        end
        core_idle();
        host_set(0, 0, 2'b00, '0, '0);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
